// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - TAP controller with instruction register and boundary-scan DR controls
module jtag_tap_ctrl #(
  parameter int              IR_W      = 2,
  parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(0),
  parameter logic [IR_W-1:0] OP_INTEST = IR_W'(1),
  parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(2),
  parameter logic [IR_W-1:0] OP_BYPASS = '1
) (
  input  logic            tck,
  input  logic            rst,
  input  logic            tms,
  input  logic            tdi,
  input  logic            bsr_tdo,
  output logic            tdo,
  output logic            tdo_en,
  output logic            extest,
  output logic            intest,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
    UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [IR_W-1:0] sreg;
  logic            bypass;
  logic            bsr_sel;

  assign tap_state = state;

  // TAP state register
  always_ff @(posedge tck) begin
    if (rst) state <= TLR;
    else     state <= nxt;
  end

  // Next-state decode from tms, plus Moore DR controls gated by instruction decode
  always_comb begin
    nxt        = state;
    bsr_sel    = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    // Anything that is not one of the three boundary opcodes falls back to bypass
    if (ir != OP_BYPASS)
      bsr_sel = (ir == OP_EXTEST) || (ir == OP_INTEST) || (ir == OP_SAMPLE);
    case (state)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    capture_dr = bsr_sel && (state == CAP_DR);
    shift_dr   = bsr_sel && (state == SH_DR);
    update_dr  = bsr_sel && (state == UPD_DR);
  end

  // IR shift/update, bypass bit, registered tdo and one-cycle instruction strobes
  always_ff @(posedge tck) begin
    if (rst) begin
      ir     <= '1;
      sreg   <= '0;
      bypass <= 1'b0;
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
      extest <= 1'b0;
      intest <= 1'b0;
    end else begin
      extest <= (state == UPD_IR) && (sreg == OP_EXTEST);
      intest <= (state == UPD_IR) && (sreg == OP_INTEST);
      tdo_en <= (state == SH_DR) || (state == SH_IR);
      // Any arrival in TLR, including via five tms=1 edges, restores BYPASS
      if (nxt == TLR)
        ir <= '1;
      else if (state == UPD_IR)
        ir <= sreg;
      case (state)
        CAP_IR: sreg <= IR_W'(1);
        SH_IR: begin
          sreg <= {tdi, sreg[IR_W-1:1]};
          tdo  <= sreg[0];
        end
        CAP_DR: bypass <= 1'b0;
        SH_DR: begin
          bypass <= tdi;
          tdo    <= bsr_sel ? bsr_tdo : bypass;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - scoreboard bench for the TAP controller
module tb_jtag_tap_ctrl;

  logic       tck = 1'b0;
  logic       rst = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       bsr_tdo = 1'b0;
  logic       tdo, tdo_en, extest, intest, capture_dr, shift_dr, update_dr;
  logic [1:0] ir;
  logic [3:0] tap_state;

  int   total = 0;
  int   bad = 0;
  logic exp_q[$];
  logic got_q[$];

  jtag_tap_ctrl dut (
    .tck(tck), .rst(rst), .tms(tms), .tdi(tdi), .bsr_tdo(bsr_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .extest(extest), .intest(intest),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .ir(ir), .tap_state(tap_state)
  );

  always #5 tck = ~tck;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: shift v LSB first through IR, update, and return to RTI
  task automatic load_ir(input logic [1:0] v);
    exp_q.delete();
    got_q.delete();
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(logic'(i == 1), v[i]);
      got_q.push_back(tdo);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    total++; if (tap_state !== 4'h0) begin bad++; $display("FAIL reset_state got=%0h want=0", tap_state); end
    total++; if (ir !== 2'b11) begin bad++; $display("FAIL reset_ir got=%0b want=11", ir); end
    total++; if ({tdo, tdo_en, extest, intest} !== 4'b0) begin bad++; $display("FAIL reset_outs got=%0b want=0000", {tdo, tdo_en, extest, intest}); end
    tick(0, 0);
    total++; if (tap_state !== 4'h1) begin bad++; $display("FAIL tlr_to_rti got=%0h want=1", tap_state); end
    total++; if ({capture_dr, shift_dr, update_dr} !== 3'b0) begin bad++; $display("FAIL reset_dr_ctl got=%0b want=000", {capture_dr, shift_dr, update_dr}); end
  endtask

  task automatic test_extest;
    logic e, g;
    load_ir(2'b00);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL ir_capture_tdo got=%0b want=%0b", g, e); end
    end
    total++; if (ir !== 2'b00) begin bad++; $display("FAIL extest_ir got=%0b want=00", ir); end
    total++; if ({extest, intest} !== 2'b10) begin bad++; $display("FAIL extest_pulse got=%0b want=10", {extest, intest}); end
    tick(0, 0);
    total++; if (extest !== 1'b0) begin bad++; $display("FAIL extest_width got=%0b want=0", extest); end
  endtask

  task automatic test_intest;
    logic       e, g;
    logic [2:0] pat;
    load_ir(2'b01);
    total++; if ({extest, intest} !== 2'b01) begin bad++; $display("FAIL intest_pulse got=%0b want=01", {extest, intest}); end
    tick(0, 0);
    total++; if (intest !== 1'b0) begin bad++; $display("FAIL intest_width got=%0b want=0", intest); end
    tick(1, 0); tick(0, 0);
    total++; if (capture_dr !== 1'b1) begin bad++; $display("FAIL intest_capture got=%0b want=1", capture_dr); end
    tick(0, 0);
    total++; if ({capture_dr, shift_dr} !== 2'b01) begin bad++; $display("FAIL intest_shift got=%0b want=01", {capture_dr, shift_dr}); end
    exp_q.delete();
    got_q.delete();
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      bsr_tdo = pat[i];
      exp_q.push_back(pat[i]);
      tick(logic'(i == 2), 0);
      got_q.push_back(tdo);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL bsr_tdo_path got=%0b want=%0b", g, e); end
    end
    total++; if (shift_dr !== 1'b0) begin bad++; $display("FAIL shift_dr_exit got=%0b want=0", shift_dr); end
    tick(1, 0);
    total++; if (update_dr !== 1'b1) begin bad++; $display("FAIL intest_update got=%0b want=1", update_dr); end
    tick(0, 0);
  endtask

  task automatic test_bypass;
    logic       e, g;
    logic [3:0] pat;
    load_ir(2'b11);
    total++; if ({ir, extest, intest} !== 4'b1100) begin bad++; $display("FAIL bypass_load got=%0b want=1100", {ir, extest, intest}); end
    tick(1, 0); tick(0, 0);
    total++; if (capture_dr !== 1'b0) begin bad++; $display("FAIL bypass_capture got=%0b want=0", capture_dr); end
    tick(0, 0);
    exp_q.delete();
    got_q.delete();
    pat = 4'b1101;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      total++; if (shift_dr !== 1'b0) begin bad++; $display("FAIL bypass_shift_dr got=%0b want=0", shift_dr); end
      tick(logic'(i == 3), pat[i]);
      got_q.push_back(tdo);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL bypass_tdo got=%0b want=%0b", g, e); end
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_tlr;
    load_ir(2'b00);
    tick(0, 0);
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    total++; if (tap_state !== 4'h6) begin bad++; $display("FAIL reach_pause_dr got=%0h want=6", tap_state); end
    for (int i = 0; i < 4; i++) tick(1, 0);
    total++; if ({tap_state, ir} !== 6'b1001_00) begin bad++; $display("FAIL four_tms_ones got=%0h/%0b want=9/00", tap_state, ir); end
    tick(1, 0);
    total++; if ({tap_state, ir} !== 6'b0000_11) begin bad++; $display("FAIL five_tms_ones got=%0h/%0b want=0/11", tap_state, ir); end
    tick(0, 0);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1);
    total++; if ({tap_state, tdo_en} !== 5'b1011_1) begin bad++; $display("FAIL mid_shift_ir got=%0h/%0b want=b/1", tap_state, tdo_en); end
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    total++; if ({tap_state, ir, tdo_en, extest, intest} !== 9'b0000_11_000) begin bad++; $display("FAIL reset_mid_shift got=%0b want=000011000", {tap_state, ir, tdo_en, extest, intest}); end
    tick(0, 0);
  endtask

  task automatic test_sample;
    load_ir(2'b10);
    total++; if ({ir, extest, intest} !== 4'b1000) begin bad++; $display("FAIL sample_load got=%0b want=1000", {ir, extest, intest}); end
    tick(1, 0); tick(0, 0);
    total++; if (capture_dr !== 1'b1) begin bad++; $display("FAIL sample_capture got=%0b want=1", capture_dr); end
    tick(0, 0);
    total++; if (shift_dr !== 1'b1) begin bad++; $display("FAIL sample_shift got=%0b want=1", shift_dr); end
    tick(1, 0); tick(1, 0);
    total++; if ({update_dr, extest, intest} !== 3'b100) begin bad++; $display("FAIL sample_update got=%0b want=100", {update_dr, extest, intest}); end
    tick(0, 0);
  endtask

  task automatic test_back_to_back;
    logic e, g, prev, b;
    load_ir(2'b00);
    load_ir(2'b01);
    total++; if ({ir, extest, intest} !== 4'b0101) begin bad++; $display("FAIL b2b_ir got=%0b want=0101", {ir, extest, intest}); end
    tick(0, 0);
    load_ir(2'b11);
    tick(1, 0); tick(0, 0); tick(0, 0);
    exp_q.delete();
    got_q.delete();
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = logic'($urandom_range(0, 1));
      exp_q.push_back(prev);
      prev = b;
      tick(logic'(i == 7), b);
      got_q.push_back(tdo);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rand_bypass_tdo got=%0b want=%0b", g, e); end
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    @(posedge tck);
    #1;
    test_reset;
    test_extest;
    test_intest;
    test_bypass;
    test_tlr;
    test_sample;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
